// File: rtl/nco_scan_pkg.sv
// Shared constants and scan FSM encoding for the NCO scan mixer.
package nco_scan_pkg;

  localparam int unsigned NCO_OUT_W      = 18;
  localparam int unsigned PINC_WIDTH_DEF = 48;

  // Output clamp limits for the saturating mix path.
  localparam int MIX_MAX = 131071;
  localparam int MIX_MIN = -131072;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLut,
    StAcc,
    StDone
  } scan_state_e;

endpackage

// File: rtl/nco_pinc_regfile.sv
// Per-voice phase increment storage: synchronous write, asynchronous read, flops cleared on reset.
module nco_pinc_regfile #(
  parameter int unsigned NCOMAX     = 3,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned PINC_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_i,
  input  logic [SEL_WIDTH-1:0]  wr_sel_i,
  input  logic [PINC_WIDTH-1:0] wr_data_i,
  input  logic [SEL_WIDTH-1:0]  rd_sel_i,
  output logic [PINC_WIDTH-1:0] rd_data_o
);

  logic [PINC_WIDTH-1:0] mem_q [NCOMAX+1];

  // Selects beyond the last voice have no backing entry and are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= int'(NCOMAX); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_i && (32'(wr_sel_i) <= NCOMAX)) begin
      mem_q[wr_sel_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (32'(rd_sel_i) <= NCOMAX) begin
      rd_data_o = mem_q[rd_sel_i];
    end
  end

endmodule

// File: rtl/nco_scan_mixer.sv
// Scans all voices of a time-multiplexed NCO once per sample period and mixes them for the DAC.
// Optional MIX_SAT_EN: +6 dB mix scaling with saturation to the 18-bit range.
module nco_scan_mixer
  import nco_scan_pkg::*;
#(
  parameter int unsigned NCOMAX     = 3,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned PINC_WIDTH = PINC_WIDTH_DEF,
  parameter int unsigned SAMPLE_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pinc_wr,
  input  logic [SEL_WIDTH-1:0]  pinc_sel,
  input  logic [PINC_WIDTH-1:0] pinc_data,
  output logic [SEL_WIDTH-1:0]  unit,
  output logic [PINC_WIDTH-1:0] phase_inc,
  output logic                  nco_ena,
  input  logic [NCO_OUT_W-1:0]  nco_out,
  output logic [NCO_OUT_W-1:0]  dac_data,
  output logic                  dac_ena,
  output logic                  overrun
);

  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned AccW = NCO_OUT_W + SEL_WIDTH;

  scan_state_e state_q, state_d;
  logic [DivW-1:0]        div_q, div_d;
  logic [SEL_WIDTH-1:0]   unit_q, unit_d;
  logic [PINC_WIDTH-1:0]  pinc_q, pinc_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [NCO_OUT_W-1:0]   dac_data_q, dac_data_d;
  logic                   dac_ena_q, dac_ena_d;
  logic                   overrun_q, overrun_d;

  logic                   tick;
  logic [SEL_WIDTH-1:0]   rd_sel;
  logic [PINC_WIDTH-1:0]  rf_rdata;
  logic signed [AccW-1:0] nco_sext;
  logic [NCO_OUT_W-1:0]   mix_scaled;

  nco_pinc_regfile #(
    .NCOMAX     (NCOMAX),
    .SEL_WIDTH  (SEL_WIDTH),
    .PINC_WIDTH (PINC_WIDTH)
  ) u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_i      (pinc_wr),
    .wr_sel_i  (pinc_sel),
    .wr_data_i (pinc_data),
    .rd_sel_i  (rd_sel),
    .rd_data_o (rf_rdata)
  );

  assign tick  = (div_q == DivW'(SAMPLE_DIV - 1));
  assign div_d = tick ? '0 : div_q + 1'b1;

  // Voice whose increment is latched on the next ADDR entry.
  assign rd_sel   = (state_q == StIdle) ? '0 : unit_q + 1'b1;
  assign nco_sext = {{SEL_WIDTH{nco_out[NCO_OUT_W-1]}}, nco_out};

`ifdef MIX_SAT_EN
  logic signed [AccW-1:0] mix_shift;
  assign mix_shift = acc_q >>> (SEL_WIDTH - 1);

  always_comb begin
    mix_scaled = mix_shift[NCO_OUT_W-1:0];
    if (mix_shift > $signed(AccW'(MIX_MAX))) begin
      mix_scaled = NCO_OUT_W'(MIX_MAX);
    end else if (mix_shift < $signed(AccW'(MIX_MIN))) begin
      mix_scaled = NCO_OUT_W'(MIX_MIN);
    end
  end
`else
  // Dividing by the voice count keeps the mix within 18 bits without clamping.
  assign mix_scaled = NCO_OUT_W'(acc_q >>> SEL_WIDTH);
`endif

  always_comb begin
    state_d    = state_q;
    unit_d     = unit_q;
    pinc_d     = pinc_q;
    acc_d      = acc_q;
    dac_data_d = dac_data_q;
    dac_ena_d  = 1'b0;
    overrun_d  = overrun_q | (tick && (state_q != StIdle));
    nco_ena    = 1'b0;

    case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StAddr;
          unit_d  = '0;
          acc_d   = '0;
          pinc_d  = rf_rdata;
        end
      end
      StAddr: state_d = StLut;
      StLut:  state_d = StAcc;
      StAcc: begin
        nco_ena = 1'b1;
        acc_d   = acc_q + nco_sext;
        if (32'(unit_q) == NCOMAX) begin
          state_d = StDone;
        end else begin
          state_d = StAddr;
          unit_d  = unit_q + 1'b1;
          pinc_d  = rf_rdata;
        end
      end
      StDone: begin
        state_d    = StIdle;
        dac_data_d = mix_scaled;
        dac_ena_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      unit_q     <= '0;
      pinc_q     <= '0;
      acc_q      <= '0;
      dac_data_q <= '0;
      dac_ena_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      unit_q     <= unit_d;
      pinc_q     <= pinc_d;
      acc_q      <= acc_d;
      dac_data_q <= dac_data_d;
      dac_ena_q  <= dac_ena_d;
      overrun_q  <= overrun_d;
    end
  end

  assign unit      = unit_q;
  assign phase_inc = pinc_q;
  assign dac_data  = dac_data_q;
  assign dac_ena   = dac_ena_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_nco_scan_mixer.sv
// Scoreboard bench for nco_scan_mixer with a behavioural NCO model; honours MIX_SAT_EN.
module tb_nco_scan_mixer;

  localparam int Div  = 64;
  localparam int Div2 = 12;
  localparam int Lat  = 14;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        pinc_wr;
  logic [1:0]  pinc_sel;
  logic [47:0] pinc_data;
  logic [1:0]  unit;
  logic [47:0] phase_inc;
  logic        nco_ena;
  logic [17:0] nco_out;
  logic [17:0] dac_data;
  logic        dac_ena;
  logic        overrun;

  logic        pinc_wr2 = 1'b0;
  logic [1:0]  pinc_sel2 = 2'd0;
  logic [47:0] pinc_data2 = 48'd0;
  logic [1:0]  unit2;
  logic [47:0] phase_inc2;
  logic        nco_ena2;
  logic [17:0] nco_out2 = 18'sd1000;
  logic [17:0] dac_data2;
  logic        dac_ena2;
  logic        overrun2;

  nco_scan_mixer #(.SAMPLE_DIV(Div)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pinc_wr   (pinc_wr),
    .pinc_sel  (pinc_sel),
    .pinc_data (pinc_data),
    .unit      (unit),
    .phase_inc (phase_inc),
    .nco_ena   (nco_ena),
    .nco_out   (nco_out),
    .dac_data  (dac_data),
    .dac_ena   (dac_ena),
    .overrun   (overrun)
  );

  nco_scan_mixer #(.SAMPLE_DIV(Div2)) dut_short (
    .clk       (clk),
    .reset_n   (reset_n),
    .pinc_wr   (pinc_wr2),
    .pinc_sel  (pinc_sel2),
    .pinc_data (pinc_data2),
    .unit      (unit2),
    .phase_inc (phase_inc2),
    .nco_ena   (nco_ena2),
    .nco_out   (nco_out2),
    .dac_data  (dac_data2),
    .dac_ena   (dac_ena2),
    .overrun   (overrun2)
  );

  int total = 0;
  int bad = 0;

  function void check(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  typedef struct {
    int val;
    int due;
  } exp_t;
  exp_t sb[$];

  int          cyc;
  bit          nco_mode;   // 0: sawtooth of phase, 1: constant
  int          const_val;
  logic [47:0] ph [4];
  logic [47:0] ref_phase [4];
  logic [47:0] ref_pinc [4];

  function automatic int saw(logic [47:0] p);
    logic signed [17:0] s;
    s = p[47:30];
    return int'(s);
  endfunction

  // Mix of four voices: floor(sum / voices) by default, or floor(sum / 2) clamped.
  function automatic int exp_mix(longint sum);
    longint q;
    longint d;
`ifdef MIX_SAT_EN
    d = 2;
`else
    d = 4;
`endif
    q = sum / d;
    if ((sum % d) != 0 && sum < 0) q = q - 1;
`ifdef MIX_SAT_EN
    if (q > 131071) q = 131071;
    if (q < -131072) q = -131072;
`endif
    return int'(q);
  endfunction

  function automatic longint ref_sum();
    longint s = 0;
    for (int v = 0; v < 4; v++) s += nco_mode ? const_val : saw(ref_phase[v]);
    return s;
  endfunction

  function automatic logic [47:0] rand48();
    return {$urandom_range(0, 65535), $urandom};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // NCO bank model: per-voice phase accumulators, output registered one cycle after unit.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < 4; v++) ph[v] <= '0;
      nco_out <= '0;
    end else begin
      nco_out <= 18'(nco_mode ? const_val : saw(ph[unit]));
      if (nco_ena) ph[unit] <= ph[unit] + phase_inc;
    end
  end

  // Reference: on each tick, predict the sample and when it appears.
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int v = 0; v < 4; v++) begin
        ref_phase[v] <= '0;
        ref_pinc[v]  <= '0;
      end
    end else begin
      if (cyc % Div == Div - 1) begin
        sb.push_back('{exp_mix(ref_sum()), cyc + Lat});
        for (int v = 0; v < 4; v++) ref_phase[v] <= ref_phase[v] + ref_pinc[v];
      end
      if (pinc_wr) ref_pinc[pinc_sel] <= pinc_data;
    end
  end

  // Monitor: strobe timing, popped samples, and the short-divider instance.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
    end else begin
      check("nco_ena", nco_ena,
            (cyc >= Div - 1) && ((cyc + 1) % Div inside {3, 6, 9, 12}));
      if ((cyc >= Div - 1) && ((cyc + 1) % Div inside {3, 6, 9, 12}))
        check("acc_unit", unit, ((cyc + 1) % Div) / 3 - 1);
      if (dac_ena) begin
        if (sb.size() == 0) begin
          check("dac_ena_unexpected", dac_ena, 0);
        end else begin
          check("dac_cycle", cyc, sb[0].due);
          check("dac_data", $signed(dac_data), sb[0].val);
          check("overrun_main", overrun, 0);
          sb.delete(0);
        end
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
        check("dac_ena_missing", dac_ena, 1);
        sb.delete(0);
      end
      if (cyc == 22) check("overrun_before", overrun2, 0);
      if (cyc inside {24, 40, 59}) check("overrun_sticky", overrun2, 1);
      if (cyc < 60) check("dac_ena_short", dac_ena2, (cyc == 25) || (cyc == 49));
      if (cyc == 25 || cyc == 49) check("dac_data_short", $signed(dac_data2), exp_mix(4000));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_phase(int p);
    int n = 0;
    do begin
      step();
      n++;
    end while ((cyc % Div != p) && (n < 200));
    if (n >= 200) check("goto_phase_timeout", n, 0);
  endtask

  task automatic wr(int sel, logic [47:0] d);
    pinc_wr   = 1'b1;
    pinc_sel  = 2'(sel);
    pinc_data = d;
    step();
    pinc_wr   = 1'b0;
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_unit"}, unit, 0);
    check({tag, "_phase_inc"}, phase_inc, 0);
    check({tag, "_nco_ena"}, nco_ena, 0);
    check({tag, "_dac_data"}, dac_data, 0);
    check({tag, "_dac_ena"}, dac_ena, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time expired before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[3];
    logic [47:0] a, b, c;
    vals = '{1000, 100000, -100000};
    pinc_wr = 1'b0;
    pinc_sel = '0;
    pinc_data = '0;
    nco_mode = 1'b1;
    const_val = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    check("reset_overrun_short", overrun2, 0);
    reset_n = 1'b1;
    repeat (200) step();

    // Constant-sample mixes, including the saturation boundaries.
    foreach (vals[i]) begin
      goto_phase(30);
      const_val = vals[i];
      repeat (2 * Div) step();
    end
    for (int k = 0; k < 3; k++) begin
      goto_phase(30);
      const_val = int'($urandom_range(0, 262143)) - 131072;
    end

    // Random increments driving a sawtooth NCO.
    goto_phase(30);
    nco_mode = 1'b0;
    for (int v = 0; v < 4; v++) wr(v, rand48());
    for (int k = 0; k < 6; k++) begin
      goto_phase(30);
      wr(int'($urandom_range(0, 3)), rand48());
    end

    // Writes landing mid-scan only take effect on the voice's next ADDR.
    goto_phase(30);
    a = rand48();
    b = rand48();
    c = rand48();
    wr(2, a);
    wr(3, b);
    goto_phase(7);
    pinc_wr   = 1'b1;
    pinc_sel  = 2'd2;
    pinc_data = 48'h0000_1000_0000;
    step();
    check("pinc2_held_unit", unit, 2);
    check("pinc2_held", phase_inc, a);
    pinc_sel  = 2'd3;
    pinc_data = c;
    step();
    pinc_wr = 1'b0;
    check("pinc3_old_unit", unit, 3);
    check("pinc3_old", phase_inc, b);
    goto_phase(6);
    check("pinc2_new", phase_inc, 48'h0000_1000_0000);
    goto_phase(9);
    check("pinc3_new", phase_inc, c);

    // Reset mid-scan, then resume.
    goto_phase(6);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("midscan_reset");
    repeat (3) step();
    nco_mode  = 1'b1;
    const_val = int'($urandom_range(0, 262143)) - 131072;
    reset_n   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      goto_phase(30);
      const_val = int'($urandom_range(0, 262143)) - 131072;
    end
    goto_phase(30);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nco_scan_mixer.md
Name: nco_scan_mixer

Overview:
Sequencer and mixer that drives the time-multiplexed sine NCO bank for the sine synth and consumes its sample output.
- Holds one phase increment per voice.
- Once per sample period, scans every voice: presents `unit`/`phase_inc`, captures the NCO sine output, and pulses `nco_ena` to advance that voice's phase.
- Sums all voices into a mix word and hands one sample to the DAC with a single-cycle strobe.

Parameters:
- NCOMAX, 3, highest voice index (voices = NCOMAX+1)
- SEL_WIDTH, 2, voice-select width; 2**SEL_WIDTH >= NCOMAX+1
- PINC_WIDTH, 48, phase increment width
- SAMPLE_DIV, 1024, clocks per output sample; must be >= 3*(NCOMAX+1)+2

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pinc_wr  in  1  write strobe for increment register file
- pinc_sel  in  SEL_WIDTH  voice written by pinc_wr
- pinc_data  in  PINC_WIDTH  increment value written
- unit  out  SEL_WIDTH  voice select to NCO
- phase_inc  out  PINC_WIDTH  increment of selected voice to NCO
- nco_ena  out  1  phase-advance strobe to NCO
- nco_out  in  18  signed sine sample from NCO (1-cycle LUT latency after unit changes)
- dac_data  out  18  signed mixed sample
- dac_ena  out  1  one-cycle strobe: dac_data updated
- overrun  out  1  sticky: sample tick arrived while scan not idle

Behaviour:
- Reset (async assert, sync release): all outputs 0, increment registers 0, state IDLE, divider 0, accumulator 0, overrun 0.
- Divider: free-running 0..SAMPLE_DIV-1. Tick is the cycle with count == SAMPLE_DIV-1; count wraps to 0.
- FSM states: IDLE, ADDR, LUT, ACC, DONE.
  - IDLE -> ADDR on tick; unit <= 0, accumulator <= 0.
  - ADDR: unit and phase_inc are registered outputs, stable. phase_inc is loaded from the register file on entry and held through ADDR/LUT/ACC. -> LUT.
  - LUT: waits out the sine table latency. -> ACC.
  - ACC: accumulator += sign-extended nco_out; nco_ena = 1 for this cycle only. If unit == NCOMAX -> DONE, else unit+1 -> ADDR.
  - DONE: dac_data <= scaled mix, dac_ena <= 1 (visible the following cycle, one cycle wide). -> IDLE.
- Latency: tick in cycle T -> dac_ena high in cycle T+3*(NCOMAX+1)+2 (T+14 at defaults).
- dac_data holds until the next update.
- Accumulator width: 18+SEL_WIDTH, signed, never overflows.
- Default scaling: dac_data = accumulator >>> SEL_WIDTH (arithmetic), low 18 bits.
- Register file writes:
  - Accepted any cycle.
  - A write to the voice currently latched affects phase_inc only at that voice's next ADDR (no mid-scan change).
  - Only NCOMAX+1 entries exist; writes with pinc_sel > NCOMAX are ignored.
- Tick while FSM is not in IDLE (only possible if SAMPLE_DIV is misconfigured): the tick is ignored and overrun is set; it clears only on reset.
- reset_n asserted mid-scan: immediate return to reset values; no partial dac_ena.
- nco_ena is never high outside ACC, and never high in two consecutive cycles.

Optional Feature:
MIX_SAT_EN
- Defined: dac_data = accumulator >>> (SEL_WIDTH-1), saturated to [-131072, +131071] (+6 dB headroom trade).
- Undefined: plain >>> SEL_WIDTH; no saturation logic is present.

Decomposition:
- Package nco_scan_pkg:
  - NCO_OUT_W = 18
  - default PINC_WIDTH
  - FSM state encoding (IDLE/ADDR/LUT/ACC/DONE)
  - MIX_MAX/MIX_MIN saturation constants
- Sub-module nco_pinc_regfile: (NCOMAX+1) x PINC_WIDTH distributed RAM with synchronous write on pinc_wr and asynchronous read by unit. Its contents are reset to 0 by a clear-on-reset sequence, or, if implemented as flops, directly by reset_n.

Test Plan:
- Setup for all tests: SAMPLE_DIV=64. The bench models the NCO: 4 phase accumulators, nco_out = f(phase) with 1-cycle latency.
- Reset, then idle 200 cycles, pinc all 0 -> all outputs 0 until first tick. dac_ena pulses every 64 cycles, 14 cycles after each tick. nco_ena appears exactly 4 times per period, at tick+3, +6, +9, +12.
- Model forces nco_out = 18'sd1000 for all voices -> dac_data = 1000. With MIX_SAT_EN -> 2000.
- nco_out = +100000 for all voices -> default dac_data = 100000. MIX_SAT_EN -> 131071. nco_out = -100000 with MIX_SAT_EN -> -131072.
- Write pinc_sel=2, pinc_data=48'h0000_1000_0000 during unit 2's LUT cycle -> phase_inc stays old value for that scan. New value is presented at unit 2's ADDR in the next period. pinc_sel=3 write on same cycle as a scan read of unit 3 behaves identically.
- Assert reset_n low at tick+7 (mid-scan) -> outputs 0 immediately, no dac_ena that period. Normal 14-cycle latency resumes after release.
- Bench override with SAMPLE_DIV=12 (< 14) -> overrun sets on the first tick that arrives outside IDLE and stays set. The scan still completes and dac_ena still pulses.
